// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the imem req/ack handshake and a 2-entry fetch buffer feeding IF/ID
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_D,
   input  logic        PC_src,
   input  logic [31:0] PC_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_F,
   output logic [31:0] PC_F,
   output logic        valid_F,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;
   state_t      state;
   logic [31:0] pc_q, pc_next, target;
   logic [31:0] buf_instr [2];
   logic [31:0] buf_pc [2];
   logic [1:0]  count, after_pop, occ_next;
   logic        pop, load, slot;
   assign valid_F       = count != 2'd0;
   assign pop           = valid_F & ~stall_D;
   assign load          = imem_req & imem_ack & (state == REQ);
   assign after_pop     = count - {1'b0, pop};
   assign occ_next      = after_pop + {1'b0, load};
   assign slot          = after_pop[0];
   assign pc_next       = pc_q + 32'd4;
   assign target        = {PC_target[31:2], 2'b00};
   assign busy          = imem_req;
   assign instruction_F = valid_F ? buf_instr[0] : NOP_INSTR;
   assign PC_F          = valid_F ? buf_pc[0] : pc_q;
   // A new request is only issued when the buffer can absorb its ack, so a load never overflows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pc_q      <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         count     <= 2'd0;
         buf_instr <= '{default: '0};
         buf_pc    <= '{default: '0};
      end else if (PC_src) begin
         count <= 2'd0;
         pc_q  <= target;
         if (imem_req && !imem_ack) state <= KILL;
         else begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= target;
         end
      end else begin
         count <= occ_next;
         if (pop) begin
            buf_instr[0] <= buf_instr[1];
            buf_pc[0]    <= buf_pc[1];
         end
         if (load) begin
            buf_instr[slot] <= imem_rdata;
            buf_pc[slot]    <= imem_addr;
            pc_q            <= pc_next;
         end
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc_q;
            end
            REQ: if (imem_ack) begin
               if (occ_next <= 2'd1) imem_addr <= pc_next;
               else begin
                  state    <= HOLD;
                  imem_req <= 1'b0;
               end
            end
            HOLD: if (occ_next <= 2'd1) begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc_q;
            end
            KILL: if (imem_ack) begin
               state     <= REQ;
               imem_addr <= pc_q;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed fetch scenarios with a fetch scoreboard checked every cycle.
module tb_fetch_sequencer;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   logic        clk, rst, stall_D, PC_src, imem_req, imem_ack, valid_F, busy;
   logic [31:0] PC_target, imem_addr, imem_rdata, instruction_F, PC_F;
   int          lat, wait_cnt, n_tests, n_fail;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t        q[$];
   logic [31:0] m_pc;
   logic        killing;

   fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst(rst), .stall_D(stall_D), .PC_src(PC_src), .PC_target(PC_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction_F(instruction_F), .PC_F(PC_F), .valid_F(valid_F), .busy(busy)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory acks after lat wait cycles of a held request
   assign imem_ack   = imem_req && (wait_cnt >= lat);
   assign imem_rdata = mem(imem_addr);
   always @(posedge clk or negedge rst)
      if (!rst) wait_cnt <= 0;
      else wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: checks buffer head each cycle, then predicts the coming edge
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         m_pc    = RESET_PC;
         killing = 1'b0;
      end else begin
         chk("sb_valid", valid_F, q.size() != 0);
         if (q.size() != 0) begin
            chk("sb_pc", PC_F, q[0].pc);
            chk("sb_instr", instruction_F, q[0].instr);
         end else chk("sb_pc_empty", PC_F, m_pc);
         if (imem_req && !killing) begin
            chk("sb_addr", imem_addr, m_pc);
            chk("sb_occ", q.size() <= 1, 1);
         end
         if (PC_src) begin
            q.delete();
            m_pc    = {PC_target[31:2], 2'b00};
            killing = imem_req && !imem_ack;
         end else begin
            if (q.size() != 0 && !stall_D) void'(q.pop_front());
            if (imem_req && imem_ack) begin
               if (killing) killing = 1'b0;
               else begin
                  q.push_back('{pc: m_pc, instr: mem(m_pc)});
                  m_pc = m_pc + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; stall_D = 1'b0; PC_src = 1'b0; PC_target = '0; lat = 0;
      #2 rst = 1'b0;
      step(2);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", valid_F, 0);
      chk("rst_busy", busy, 0);
      chk("rst_instr", instruction_F, NOP_INSTR);
      chk("rst_pcf", PC_F, RESET_PC);
      rst = 1'b1;
      // zero-wait streaming
      step(1); chk("t1_req", imem_req, 1); chk("t1_addr0", imem_addr, 32'h0); chk("t1_valid0", valid_F, 0);
      step(1); chk("t1_addr4", imem_addr, 32'h4); chk("t1_valid1", valid_F, 1);
      chk("t1_pcf0", PC_F, 32'h0); chk("t1_instr0", instruction_F, mem(32'h0));
      step(1); chk("t1_addr8", imem_addr, 32'h8); chk("t1_pcf4", PC_F, 32'h4);
      step(1); chk("t1_addrc", imem_addr, 32'hC); chk("t1_pcf8", PC_F, 32'h8);
      // decode stall fills the buffer and drops req
      stall_D = 1'b1;
      step(1); chk("t2_req_drop", imem_req, 0); chk("t2_pcf_frozen", PC_F, 32'h8); chk("t2_busy", busy, 0);
      step(3); chk("t2_req_hold", imem_req, 0); chk("t2_pcf_hold", PC_F, 32'h8);
      chk("t2_instr_hold", instruction_F, mem(32'h8)); chk("t2_valid_hold", valid_F, 1);
      stall_D = 1'b0;
      step(1); chk("t2_pcf_c", PC_F, 32'hC); chk("t2_req_resume", imem_req, 1); chk("t2_addr10", imem_addr, 32'h10);
      step(1); chk("t2_pcf_10", PC_F, 32'h10); chk("t2_addr14", imem_addr, 32'h14);
      // slow memory, redirect mid-wait
      lat = 2;
      step(1); chk("t3_wait_addr", imem_addr, 32'h14); chk("t3_wait_req", imem_req, 1); chk("t3_wait_valid", valid_F, 0);
      PC_src = 1'b1; PC_target = 32'h0000_0103;
      step(1); PC_src = 1'b0;
      chk("t3_kill_req", imem_req, 1); chk("t3_kill_addr", imem_addr, 32'h14);
      chk("t3_kill_valid", valid_F, 0); chk("t3_kill_pcf", PC_F, 32'h100);
      step(1); chk("t3_new_addr", imem_addr, 32'h100); chk("t3_new_req", imem_req, 1); chk("t3_new_valid", valid_F, 0);
      step(3); chk("t3_valid", valid_F, 1); chk("t3_pcf", PC_F, 32'h100); chk("t3_instr", instruction_F, mem(32'h100));
      // redirect coincident with ack, then double redirect during KILL
      lat = 0; stall_D = 1'b1; PC_src = 1'b1; PC_target = 32'h200;
      step(1); PC_src = 1'b0;
      chk("t4_flush_valid", valid_F, 0); chk("t4_req", imem_req, 1); chk("t4_addr", imem_addr, 32'h200);
      lat = 2; PC_src = 1'b1; PC_target = 32'h300;
      step(1); PC_target = 32'h404;
      chk("t4_kill_addr", imem_addr, 32'h200); chk("t4_kill_req", imem_req, 1); chk("t4_kill_valid", valid_F, 0);
      step(1); PC_src = 1'b0; chk("t4_kill2_addr", imem_addr, 32'h200);
      step(1); chk("t4_last_addr", imem_addr, 32'h404); chk("t4_last_req", imem_req, 1); chk("t4_last_valid", valid_F, 0);
      step(3); chk("t4_valid", valid_F, 1); chk("t4_pcf", PC_F, 32'h404); chk("t4_instr", instruction_F, mem(32'h404));
      // PC wraparound
      lat = 0; stall_D = 1'b0; PC_src = 1'b1; PC_target = 32'hFFFF_FFFF;
      step(1); PC_src = 1'b0; chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC); chk("t5_valid", valid_F, 0);
      step(1); chk("t5_addr_wrap", imem_addr, 32'h0); chk("t5_pcf_top", PC_F, 32'hFFFF_FFFC);
      chk("t5_instr_top", instruction_F, mem(32'hFFFF_FFFC));
      step(1); chk("t5_pcf_0", PC_F, 32'h0); chk("t5_addr4", imem_addr, 32'h4);
      // async reset mid-request
      lat = 2; stall_D = 1'b1;
      step(1); chk("t6_pre_req", imem_req, 1); chk("t6_pre_valid", valid_F, 1);
      rst = 1'b0;
      #1;
      chk("t6_req", imem_req, 0); chk("t6_valid", valid_F, 0); chk("t6_instr", instruction_F, NOP_INSTR);
      chk("t6_busy", busy, 0); chk("t6_pcf", PC_F, RESET_PC); chk("t6_addr", imem_addr, RESET_PC);
      step(2); rst = 1'b1; lat = 0; stall_D = 1'b0;
      step(1); chk("t6_rel_req", imem_req, 1); chk("t6_rel_addr", imem_addr, RESET_PC);
      step(1); chk("t6_rel_pcf", PC_F, RESET_PC); chk("t6_rel_valid", valid_F, 1); chk("t6_rel_addr4", imem_addr, 32'h4);
      step(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
